// File: rtl/adel_pkg.sv
// rtl/adel_pkg.sv - shared types and constants for the adel instruction-memory controller
package adel_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] STOP_NONE   = 2'd0;
    localparam logic [1:0] STOP_HALT   = 2'd1;
    localparam logic [1:0] STOP_BUDGET = 2'd2;
    localparam logic [1:0] STOP_BOTH   = 2'd3;

    localparam int INST_W_DEF = 16;

endpackage

// File: rtl/adel_imem.sv
// rtl/adel_imem.sv - single write port, async read instruction array with valid bitmap
module adel_imem #(
    parameter int INST_W = 16,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [INST_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [INST_W-1:0] rdata_o,
    output logic              rvalid_o
);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    // Contents are never reset; the valid bitmap masks stale words
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Valid bitmap: set on write, cleared by reset or program discard
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_q <= '0;
        end else if (clr_i) begin
            vld_q <= '0;
        end else if (we_i) begin
            vld_q[waddr_i] <= 1'b1;
        end
    end

    assign rdata_o  = mem_q[raddr_i];
    assign rvalid_o = vld_q[raddr_i];

endmodule

// File: rtl/adel_imem_ctrl.sv
// rtl/adel_imem_ctrl.sv - program loader, fetch mux and run controller for the adel core
module adel_imem_ctrl
    import adel_pkg::*;
#(
    parameter int                INST_W = INST_W_DEF,
    parameter int                DEPTH  = 64,
    parameter int                PC_W   = 8,
    parameter int                WRAP   = 1,
    parameter logic [INST_W-1:0] FILL   = '0,
    parameter int                CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [INST_W-1:0]      load_data,
    input  logic                   load_last,
    input  logic                   start,
    input  logic                   reload,
    input  logic [CNT_W-1:0]       max_cycles,
    input  logic                   halt,
    input  logic [PC_W-1:0]        pc,
    output logic [INST_W-1:0]      inst,
    output logic                   core_nrst,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] prog_len,
    output logic [CNT_W-1:0]       cycle_count,
    output logic                   oob,
    output logic [1:0]             stop_cause
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e            state_q;
    logic [AW-1:0]     ptr_q;
    logic [LW-1:0]     len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              oob_q;
    logic [1:0]        stop_q;
    logic              core_nrst_q;

    logic              load_hs;
    logic              go_load;
    logic              go_run;
    logic              pc_oob;
    logic              budget_hit;
    logic [INST_W-1:0] rdata;
    logic              rvalid;

    assign load_hs    = load_valid && (state_q == ST_LOAD);
    assign go_load    = reload && (state_q != ST_LOAD);
    assign go_run     = start && !reload && ((state_q == ST_READY) || (state_q == ST_DONE));
    assign pc_oob     = (WRAP == 0) && (32'(pc) >= DEPTH);
    assign budget_hit = (max_cycles != '0) && (cnt_q == max_cycles - CNT_W'(1));

    adel_imem #(
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_imem (
        .clk      (clk),
        .nrst     (nrst),
        .clr_i    (go_load),
        .we_i     (load_hs),
        .waddr_i  (ptr_q),
        .wdata_i  (load_data),
        .raddr_i  (pc[AW-1:0]),
        .rdata_o  (rdata),
        .rvalid_o (rvalid)
    );

    // Fetch: unloaded or out-of-range addresses read as FILL
    always_comb begin
        inst = (pc_oob || !rvalid) ? FILL : rdata;
    end

    // Run controller: load sequencing, run start/stop, cycle budget and status flags
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_LOAD;
            ptr_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            oob_q       <= 1'b0;
            stop_q      <= STOP_NONE;
            core_nrst_q <= 1'b0;
        end else if (go_load) begin
            state_q     <= ST_LOAD;
            ptr_q       <= '0;
            len_q       <= '0;
            core_nrst_q <= 1'b0;
        end else if (go_run) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            oob_q       <= 1'b0;
            stop_q      <= STOP_NONE;
            core_nrst_q <= 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_hs) begin
                        ptr_q <= ptr_q + AW'(1);
                        len_q <= len_q + LW'(1);
                        // A full memory ends the load regardless of load_last
                        if (load_last || (ptr_q == LAST_IDX)) begin
                            state_q <= ST_READY;
                        end
                    end
                end
                ST_RUN: begin
                    if (!(&cnt_q)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (pc_oob) begin
                        oob_q <= 1'b1;
                    end
                    if (halt || budget_hit) begin
                        state_q     <= ST_DONE;
                        stop_q      <= {budget_hit, halt};
                        core_nrst_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign load_ready  = (state_q == ST_LOAD);
    assign core_nrst   = core_nrst_q;
    assign state       = state_q;
    assign prog_len    = len_q;
    assign cycle_count = cnt_q;
    assign oob         = oob_q;
    assign stop_cause  = stop_q;

endmodule

// File: tb/tb_adel_imem_ctrl.sv
// tb/tb_adel_imem_ctrl.sv - randomized self-checking bench for adel_imem_ctrl against a behavioural model
module tb_adel_imem_ctrl;

    localparam int          INST_W = 16;
    localparam int          DEPTH  = 64;
    localparam int          PC_W   = 8;
    localparam int          CNT_W  = 16;
    localparam logic [15:0] FILL   = 16'hBEEF;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              load_valid = 1'b0;
    logic [INST_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              start = 1'b0;
    logic              reload = 1'b0;
    logic [CNT_W-1:0]  max_cycles = '0;
    logic              halt = 1'b0;
    logic [PC_W-1:0]   pc = '0;

    logic              lr_w, lr_n, cn_w, cn_n, oob_w, oob_n;
    logic [INST_W-1:0] inst_w, inst_n;
    logic [1:0]        st_w, st_n, sc_w, sc_n;
    logic [6:0]        pl_w, pl_n;
    logic [CNT_W-1:0]  cc_w, cc_n;

    adel_imem_ctrl #(.INST_W(INST_W), .DEPTH(DEPTH), .PC_W(PC_W), .WRAP(1), .FILL(FILL), .CNT_W(CNT_W)) u_wrap (
        .clk(clk), .nrst(nrst), .load_valid(load_valid), .load_ready(lr_w), .load_data(load_data),
        .load_last(load_last), .start(start), .reload(reload), .max_cycles(max_cycles), .halt(halt),
        .pc(pc), .inst(inst_w), .core_nrst(cn_w), .state(st_w), .prog_len(pl_w),
        .cycle_count(cc_w), .oob(oob_w), .stop_cause(sc_w));

    adel_imem_ctrl #(.INST_W(INST_W), .DEPTH(DEPTH), .PC_W(PC_W), .WRAP(0), .FILL(FILL), .CNT_W(CNT_W)) u_nowrap (
        .clk(clk), .nrst(nrst), .load_valid(load_valid), .load_ready(lr_n), .load_data(load_data),
        .load_last(load_last), .start(start), .reload(reload), .max_cycles(max_cycles), .halt(halt),
        .pc(pc), .inst(inst_n), .core_nrst(cn_n), .state(st_n), .prog_len(pl_n),
        .cycle_count(cc_n), .oob(oob_n), .stop_cause(sc_n));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program image plus run bookkeeping
    int          m_state;
    logic [15:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];
    int          m_len;
    int          m_cnt;
    bit          m_oob;
    int          m_stop;

    function automatic void m_discard();
        m_state = 0;
        m_len   = 0;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    endfunction

    function automatic void m_reset();
        m_discard();
        m_cnt  = 0;
        m_oob  = 1'b0;
        m_stop = 0;
    endfunction

    function automatic logic [15:0] m_inst(input bit wrap, input int p);
        int i;
        i = p % DEPTH;
        if (!wrap && p >= DEPTH) return FILL;
        return m_vld[i] ? m_mem[i] : FILL;
    endfunction

    function automatic void m_step();
        bit hh, bb;
        case (m_state)
            0: if (load_valid) begin
                m_mem[m_len] = load_data;
                m_vld[m_len] = 1'b1;
                m_len++;
                if (load_last || m_len == DEPTH) m_state = 1;
            end
            1, 3: if (reload) m_discard();
                  else if (start) begin m_state = 2; m_cnt = 0; m_oob = 1'b0; m_stop = 0; end
            default: if (reload) m_discard();
            else begin
                hh = halt;
                bb = (int'(max_cycles) != 0) && (m_cnt == int'(max_cycles) - 1);
                if (m_cnt < 65535) m_cnt++;
                if (int'(pc) >= DEPTH) m_oob = 1'b1;
                if (hh || bb) begin
                    m_state = 3;
                    m_stop  = (hh ? 1 : 0) + (bb ? 2 : 0);
                end
            end
        endcase
    endfunction

    always @(posedge clk) if (nrst) m_step();
    always @(negedge nrst) m_reset();

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        check("state_w", 32'(st_w), 32'(m_state));
        check("state_n", 32'(st_n), 32'(m_state));
        check("load_ready", 32'(lr_w), 32'(m_state == 0));
        check("core_nrst", 32'(cn_w), 32'(m_state == 2));
        check("core_nrst_n", 32'(cn_n), 32'(m_state == 2));
        check("prog_len", 32'(pl_w), 32'(m_len));
        check("cycle_count", 32'(cc_w), 32'(m_cnt));
        check("stop_cause", 32'(sc_w), 32'(m_stop));
        check("oob_wrap", 32'(oob_w), 32'(0));
        check("oob_nowrap", 32'(oob_n), 32'(m_oob));
        check("inst_wrap", 32'(inst_w), 32'(m_inst(1'b1, int'(pc))));
        check("inst_nowrap", 32'(inst_n), 32'(m_inst(1'b0, int'(pc))));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [15:0] lit3 [3];
    logic [15:0] wd [70];

    initial begin
        m_reset();
        lit3[0] = 16'h1111; lit3[1] = 16'h2222; lit3[2] = 16'h3333;
        repeat (3) tick();
        nrst = 1'b1;
        check("rst_state", 32'(st_w), 32'd0);
        check("rst_load_ready", 32'(lr_w), 32'd1);
        check("rst_core_nrst", 32'(cn_w), 32'd0);
        check("rst_prog_len", 32'(pl_w), 32'd0);

        // Three-word program
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = lit3[i]; load_last = (i == 2);
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        check("p3_len", 32'(pl_w), 32'd3);
        check("p3_state", 32'(st_w), 32'd1);
        check("p3_ready_low", 32'(lr_w), 32'd0);
        pc = 8'd1; #1;
        check("p3_pc1", 32'(inst_w), 32'h2222);
        pc = 8'd5; #1;
        check("p3_pc5_fill", 32'(inst_w), 32'hBEEF);
        start = 1'b1; tick(); start = 1'b0;
        check("run_core_nrst", 32'(cn_w), 32'd1);
        repeat (5) tick();
        halt = 1'b1; tick(); halt = 1'b0;
        check("halt_cause", 32'(sc_w), 32'd1);
        check("halt_count", 32'(cc_w), 32'd6);
        check("halt_core_nrst", 32'(cn_w), 32'd0);

        // reload beats start in DONE
        reload = 1'b1; start = 1'b1; tick(); reload = 1'b0; start = 1'b0;
        check("reload_state", 32'(st_w), 32'd0);
        check("reload_len", 32'(pl_w), 32'd0);

        // Overlong stream: only DEPTH words taken
        for (int i = 0; i < 70; i++) begin
            wd[i] = 16'($urandom);
            load_valid = 1'b1; load_data = wd[i];
            tick();
        end
        load_valid = 1'b0;
        check("full_ready_low", 32'(lr_w), 32'd0);
        check("full_len", 32'(pl_w), 32'd64);
        pc = 8'd63; #1;
        check("full_pc63", 32'(inst_w), 32'(wd[63]));

        // Budget stop
        pc = 8'd0; max_cycles = 16'd100;
        start = 1'b1; tick(); start = 1'b0;
        repeat (110) tick();
        check("budget_state", 32'(st_w), 32'd3);
        check("budget_count", 32'(cc_w), 32'd100);
        check("budget_cause", 32'(sc_w), 32'd2);
        check("budget_core_nrst", 32'(cn_w), 32'd0);

        // Halt and budget in the same cycle
        max_cycles = 16'd11;
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        halt = 1'b1; tick(); halt = 1'b0;
        check("both_cause", 32'(sc_w), 32'd3);
        check("both_count", 32'(cc_w), 32'd11);

        // Out-of-range pc with and without wrap
        max_cycles = 16'd0;
        start = 1'b1; tick(); start = 1'b0;
        pc = 8'h45; #1;
        check("oob_inst_nowrap", 32'(inst_n), 32'hBEEF);
        check("oob_inst_wrap", 32'(inst_w), 32'(wd[5]));
        tick();
        check("oob_set", 32'(oob_n), 32'd1);
        check("oob_wrap_clear", 32'(oob_w), 32'd0);
        pc = 8'd0; tick();
        check("oob_sticky", 32'(oob_n), 32'd1);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            load_valid = ($urandom_range(0, 1) == 1);
            load_data  = 16'($urandom);
            load_last  = ($urandom_range(0, 9) == 0);
            start      = ($urandom_range(0, 7) == 0);
            reload     = ($urandom_range(0, 60) == 0);
            halt       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) max_cycles = 16'($urandom_range(0, 40));
            pc         = 8'($urandom_range(0, 255));
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0; start = 1'b0; halt = 1'b0; pc = 8'd0; max_cycles = 16'd0;

        // Async reset in the middle of a run
        reload = 1'b1; tick(); reload = 1'b0;
        load_valid = 1'b1; load_data = 16'h0A0A; load_last = 1'b1; tick();
        load_valid = 1'b0; load_last = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        check("pre_rst_run", 32'(st_w), 32'd2);
        #1 nrst = 1'b0;
        #1;
        check("arst_state", 32'(st_w), 32'd0);
        check("arst_core_nrst", 32'(cn_w), 32'd0);
        check("arst_count", 32'(cc_w), 32'd0);
        check("arst_len", 32'(pl_w), 32'd0);
        #1 nrst = 1'b1;
        tick();
        check("post_rst_state", 32'(st_w), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adel_imem_ctrl.md
Name: adel_imem_ctrl

Overview:
- Parametrised instruction-memory and run controller for the adel core.
- Accepts a program over a valid/ready load stream and serves instructions combinationally at the core's pc.
- Holds the core in reset until started, then releases it for a bounded cycle budget or until the core signals halt.
- Replaces free-running testbench-driven instruction arrays and fixed 64-word pc wrap.

Parameters:
- INST_W, 16, instruction width in bits.
- DEPTH, 64, number of instruction words (power of two, >=2).
- PC_W, 8, core pc width; PC_W >= clog2(DEPTH).
- WRAP, 1, 1: pc indexes modulo DEPTH; 0: pc >= DEPTH returns FILL and flags oob.
- FILL, 0, instruction returned for unloaded or out-of-range addresses.
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- load_valid  in  1  load word present.
- load_ready  out  1  controller accepts load word.
- load_data  in  INST_W  instruction word.
- load_last  in  1  final word of program.
- start  in  1  begin/re-begin execution.
- reload  in  1  discard program, return to LOAD.
- max_cycles  in  CNT_W  run budget in cycles; 0 = unlimited.
- halt  in  1  core-requested stop.
- pc  in  PC_W  core fetch address.
- inst  out  INST_W  instruction at pc (combinational).
- core_nrst  out  1  active-low reset to core.
- state  out  2  LOAD=0, READY=1, RUN=2, DONE=3.
- prog_len  out  clog2(DEPTH)+1  words loaded.
- cycle_count  out  CNT_W  cycles spent in RUN.
- oob  out  1  sticky: pc >= DEPTH seen in RUN with WRAP=0.
- stop_cause  out  2  0 none, 1 halt, 2 budget, 3 both.

Behaviour:
- Reset (async, nrst low):
  - state=LOAD, write pointer=0, valid bitmap cleared, prog_len=0.
  - cycle_count=0, oob=0, stop_cause=0.
  - core_nrst=0; load_ready=1 after reset release.
- LOAD: load_ready=1.
  - Handshake when load_valid & load_ready: write load_data at ptr, set valid bit, ptr++, prog_len++.
  - Go to READY on a handshake with load_last, or on the handshake writing DEPTH-1 (memory full; load_last ignored there).
- READY: load_ready=0.
  - start -> RUN next cycle; cycle_count=0, oob=0, stop_cause=0.
  - core_nrst=1 from the first RUN cycle.
- RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - halt=1 -> DONE next cycle.
  - max_cycles!=0 and cycle_count==max_cycles-1 -> DONE next cycle.
  - stop_cause records which condition fired; both in the same cycle = 3.
  - core_nrst=0 from the first DONE cycle.
- DONE: cycle_count, oob and stop_cause hold.
  - start -> RUN, with the same counter/flag clears as from READY; program retained.
- reload in READY, RUN or DONE -> LOAD next cycle: ptr=0, bitmap cleared, prog_len=0, core_nrst=0.
- reload and start in the same cycle: reload wins.
- start and load_valid in LOAD are ignored for start; loading proceeds.
- halt outside RUN is ignored.
- Fetch:
  - idx = pc[clog2(DEPTH)-1:0].
  - inst = mem[idx] if the valid bit is set, else FILL.
  - WRAP=0 and pc >= DEPTH: inst=FILL; oob set on the next edge, only while in RUN.
- Memory: flop array; no reset of contents needed, since the bitmap masks stale data.
- reload in mid-RUN cuts the run immediately; cycle_count is cleared on the next start.

Decomposition:
- Package adel_pkg:
  - state enum (LOAD, READY, RUN, DONE).
  - stop_cause encodings.
  - INST_W default constant.
- Sub-module adel_imem: DEPTH x INST_W write-port/async-read array plus valid bitmap with clear.
- Controller FSM, counter and fetch muxing stay in adel_imem_ctrl.

Test Plan:
- Load 3 words 1111, 2222, 3333 with load_last on the third -> prog_len=3, state=READY.
  - Then start -> core_nrst=1 next cycle.
  - pc=1 gives 2222; pc=5 gives FILL.
- DEPTH=64, stream 70 words with no load_last -> only 64 accepted, load_ready=0 after the 64th.
  - pc=63 gives word 63.
- max_cycles=100, halt=0 -> DONE after exactly 100 RUN cycles, cycle_count=100, stop_cause=2, core_nrst=0.
- halt asserted on cycle 10 with max_cycles=11 -> stop_cause=3 after both fire together.
  - Separately, halt alone -> stop_cause=1.
- WRAP=0, DEPTH=64: pc=0x45 -> inst=FILL, oob=1 and sticky.
  - With WRAP=1 the same pc returns word 5, oob=0.
- reload and start together in DONE -> LOAD, prog_len=0.
  - Async nrst pulse mid-RUN -> immediate LOAD, core_nrst=0, counters cleared.
